// File: rtl/fp_sqrt_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : fp_sqrt_result_stage
// Purpose  : Registered result stage behind a combinational DW_fp_sqrt.
//            Captures the square-root result and its 8-bit DW status word
//            into a 2-entry skid FIFO with valid/ready handshakes on both
//            sides. Invalid results can be replaced by the canonical qNaN.
//            Sticky exception flags and saturating invalid/result counters
//            are kept for software readout.
//
// Ports    : clk           - single clock, all state on rising edge
//            rst_n         - synchronous, active-low reset
//            in_valid      - upstream result valid
//            in_ready      - stage can accept a result this cycle
//            in_z          - sqrt result z
//            in_status     - DW status word ([2] = invalid)
//            out_valid     - head entry valid
//            out_ready     - downstream accepts head entry
//            out_z         - head result (after canonicalisation)
//            out_status    - head status (unmodified)
//            flags_clr     - clears sticky_flags and both counters
//            sticky_flags  - OR of in_status over accepted transfers
//            invalid_cnt   - accepted transfers flagged invalid, saturating
//            result_cnt    - total accepted transfers, saturating
//
// Revision : 1.0 - initial release
// ============================================================================
module fp_sqrt_result_stage #(
    parameter int sig_width = 23,
    parameter int exp_width = 8,
    parameter int canon_nan = 1,
    parameter int cnt_width = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,

    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [sig_width+exp_width:0]       in_z,
    input  logic [7:0]                         in_status,

    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [sig_width+exp_width:0]       out_z,
    output logic [7:0]                         out_status,

    input  logic                               flags_clr,
    output logic [7:0]                         sticky_flags,
    output logic [cnt_width-1:0]               invalid_cnt,
    output logic [cnt_width-1:0]               result_cnt
);

    localparam int c_z_width = sig_width + exp_width + 1;

    // Canonical quiet NaN: sign 0, exponent all ones, significand MSB set.
    localparam logic [c_z_width-1:0] c_qnan =
        {1'b0, {exp_width{1'b1}}, 1'b1, {(sig_width-1){1'b0}}};

    localparam logic [cnt_width-1:0] c_cnt_one = {{(cnt_width-1){1'b0}}, 1'b1};
    localparam logic [1:0]           c_depth   = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // The head entry lives directly in the output registers so out_* are
    // flop-driven; the skid entry holds the second word while the head
    // is back-pressured.
    logic [1:0]              count_q,        count_d;
    logic [c_z_width-1:0]    head_z_q,       head_z_d;
    logic [7:0]              head_status_q,  head_status_d;
    logic [c_z_width-1:0]    skid_z_q,       skid_z_d;
    logic [7:0]              skid_status_q,  skid_status_d;
    logic [7:0]              sticky_q,       sticky_d;
    logic [cnt_width-1:0]    invalid_cnt_q,  invalid_cnt_d;
    logic [cnt_width-1:0]    result_cnt_q,   result_cnt_d;

    logic                    w_accept;
    logic                    w_pop;
    logic [c_z_width-1:0]    w_store_z;

    // ------------------------------------------------------------------
    // Handshakes: both readies/valids decode the registered count only,
    // so there is no combinational path from out_ready to in_ready.
    // ------------------------------------------------------------------
    assign in_ready  = (count_q != c_depth);
    assign out_valid = (count_q != 2'd0);
    assign w_accept  = in_valid  & in_ready;
    assign w_pop     = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Canonicalisation happens on the way in, so both FIFO slots always
    // hold the final output value and the status is never altered.
    // ------------------------------------------------------------------
    generate
        if (canon_nan != 0) begin : g_canon
            assign w_store_z = in_status[2] ? c_qnan : in_z;
        end else begin : g_raw
            assign w_store_z = in_z;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FIFO next-state
    // ------------------------------------------------------------------
    always_comb begin
        count_d       = count_q;
        head_z_d      = head_z_q;
        head_status_d = head_status_q;
        skid_z_d      = skid_z_q;
        skid_status_d = skid_status_q;

        case ({w_accept, w_pop})
            2'b10: begin
                // Fill the head first; only a non-empty FIFO uses the skid.
                if (count_q == 2'd0) begin
                    head_z_d      = w_store_z;
                    head_status_d = in_status;
                end else begin
                    skid_z_d      = w_store_z;
                    skid_status_d = in_status;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                // Promote the skid word; with one entry the head just goes
                // invalid and keeps its last value on out_*.
                if (count_q == c_depth) begin
                    head_z_d      = skid_z_q;
                    head_status_d = skid_status_q;
                end
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Accept requires count != 2 and pop requires count != 0,
                // so count is 1 here: the new word replaces the head.
                head_z_d      = w_store_z;
                head_status_d = in_status;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sticky flags and saturating counters. A coincident clear is applied
    // before the accept, so the accepted transfer is still recorded.
    // ------------------------------------------------------------------
    function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] v);
        return (&v) ? v : (v + c_cnt_one);
    endfunction

    always_comb begin
        logic [7:0]           sticky_base;
        logic [cnt_width-1:0] invalid_base;
        logic [cnt_width-1:0] result_base;

        sticky_base  = flags_clr ? 8'h00          : sticky_q;
        invalid_base = flags_clr ? {cnt_width{1'b0}} : invalid_cnt_q;
        result_base  = flags_clr ? {cnt_width{1'b0}} : result_cnt_q;

        sticky_d      = sticky_base;
        invalid_cnt_d = invalid_base;
        result_cnt_d  = result_base;

        if (w_accept) begin
            sticky_d     = sticky_base | in_status;
            result_cnt_d = sat_inc(result_base);
            if (in_status[2]) begin
                invalid_cnt_d = sat_inc(invalid_base);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q       <= 2'd0;
            head_z_q      <= '0;
            head_status_q <= 8'h00;
            skid_z_q      <= '0;
            skid_status_q <= 8'h00;
            sticky_q      <= 8'h00;
            invalid_cnt_q <= '0;
            result_cnt_q  <= '0;
        end else begin
            count_q       <= count_d;
            head_z_q      <= head_z_d;
            head_status_q <= head_status_d;
            skid_z_q      <= skid_z_d;
            skid_status_q <= skid_status_d;
            sticky_q      <= sticky_d;
            invalid_cnt_q <= invalid_cnt_d;
            result_cnt_q  <= result_cnt_d;
        end
    end

    assign out_z        = head_z_q;
    assign out_status   = head_status_q;
    assign sticky_flags = sticky_q;
    assign invalid_cnt  = invalid_cnt_q;
    assign result_cnt   = result_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_sqrt_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_sqrt_result_stage
// Purpose  : Self-checking bench for fp_sqrt_result_stage. Three instances
//            share one stimulus stream: default build (qNaN canonicalisation,
//            16-bit counters), a raw build (no canonicalisation) and a build
//            with 4-bit counters. A queue-based reference model predicts the
//            handshakes, data order, sticky flags and counter values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_sqrt_result_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        flags_clr = 1'b0;
    logic [31:0] in_z = 32'h0;
    logic [7:0]  in_status = 8'h0;

    always #5 clk = ~clk;

    // default build
    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_z;
    logic [7:0]  a_out_status, a_sticky;
    logic [15:0] a_inv, a_res;
    // raw build
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_z;
    logic [7:0]  b_out_status, b_sticky;
    logic [15:0] b_inv, b_res;
    // 4-bit counter build
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_z;
    logic [7:0]  s_out_status, s_sticky;
    logic [3:0]  s_inv, s_res;

    fp_sqrt_result_stage #(.sig_width(23), .exp_width(8), .canon_nan(1), .cnt_width(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_z(in_z), .in_status(in_status),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_z(a_out_z), .out_status(a_out_status),
        .flags_clr(flags_clr), .sticky_flags(a_sticky), .invalid_cnt(a_inv), .result_cnt(a_res)
    );

    fp_sqrt_result_stage #(.sig_width(23), .exp_width(8), .canon_nan(0), .cnt_width(16)) u_raw (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_z(in_z), .in_status(in_status),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_z(b_out_z), .out_status(b_out_status),
        .flags_clr(flags_clr), .sticky_flags(b_sticky), .invalid_cnt(b_inv), .result_cnt(b_res)
    );

    fp_sqrt_result_stage #(.sig_width(23), .exp_width(8), .canon_nan(1), .cnt_width(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_z(in_z), .in_status(in_status),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_z(s_out_z), .out_status(s_out_status),
        .flags_clr(flags_clr), .sticky_flags(s_sticky), .invalid_cnt(s_inv), .result_cnt(s_res)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ------------------------------------------------------------------
    // Reference model: a plain queue of accepted words plus unbounded
    // event totals; saturation is applied only when comparing.
    // ------------------------------------------------------------------
    logic [31:0] mq_z[$];
    logic [7:0]  mq_s[$];
    logic [31:0] m_zc = 32'h0;   // last shown head, canonicalised
    logic [31:0] m_zr = 32'h0;   // last shown head, raw
    logic [7:0]  m_s = 8'h0;
    logic [7:0]  m_sticky = 8'h0;
    int          m_res = 0;
    int          m_inv = 0;

    function automatic logic [31:0] canon(input logic [31:0] z, input logic [7:0] s);
        return s[2] ? 32'h7FC00000 : z;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk) begin
        bit acc, pop;
        if (!rst_n) begin
            mq_z.delete(); mq_s.delete();
            m_zc = 0; m_zr = 0; m_s = 0; m_sticky = 0; m_res = 0; m_inv = 0;
        end else begin
            acc = in_valid && (mq_z.size() < 2);
            pop = out_ready && (mq_z.size() > 0);
            if (pop) begin
                void'(mq_z.pop_front());
                void'(mq_s.pop_front());
            end
            if (acc) begin
                mq_z.push_back(in_z);
                mq_s.push_back(in_status);
            end
            if (flags_clr) begin
                m_sticky = 0; m_res = 0; m_inv = 0;
            end
            if (acc) begin
                m_sticky = m_sticky | in_status;
                m_res++;
                if (in_status[2]) m_inv++;
            end
            if (mq_z.size() > 0) begin
                m_zr = mq_z[0];
                m_zc = canon(mq_z[0], mq_s[0]);
                m_s  = mq_s[0];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flags_clr = 1'b0;
        step(); step();
        n_checks++;
        if ({a_out_valid, a_in_ready} !== 2'b01)
            begin n_errors++; $display("FAIL reset_handshake: got valid/ready %b%b, want 01", a_out_valid, a_in_ready); end
        n_checks++;
        if ({a_out_z, a_out_status} !== 40'h0)
            begin n_errors++; $display("FAIL reset_data: got z=%h st=%h, want 0", a_out_z, a_out_status); end
        n_checks++;
        if ({a_sticky, a_inv, a_res, s_inv, s_res} !== 48'h0)
            begin n_errors++; $display("FAIL reset_flags: got sticky=%h inv=%0d res=%0d", a_sticky, a_inv, a_res); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_z = 32'h40000000; in_status = 8'h00; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_z !== 32'h40000000)
            begin n_errors++; $display("FAIL single_out: got v=%b z=%h, want 1 40000000", a_out_valid, a_out_z); end
        n_checks++;
        if (a_res !== 16'd1 || a_sticky !== 8'h00)
            begin n_errors++; $display("FAIL single_flags: got res=%0d sticky=%h, want 1 00", a_res, a_sticky); end
        step();
    endtask

    task automatic test_invalid();
        in_valid = 1'b1; in_z = 32'h7F800001; in_status = 8'h04; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (a_out_z !== 32'h7FC00000 || a_out_status !== 8'h04)
            begin n_errors++; $display("FAIL invalid_canon: got z=%h st=%h, want 7fc00000 04", a_out_z, a_out_status); end
        n_checks++;
        if (b_out_z !== 32'h7F800001)
            begin n_errors++; $display("FAIL invalid_raw: got z=%h, want 7f800001", b_out_z); end
        n_checks++;
        if (a_inv !== 16'd1 || a_sticky !== 8'h04)
            begin n_errors++; $display("FAIL invalid_flags: got inv=%0d sticky=%h, want 1 04", a_inv, a_sticky); end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1; in_valid = 1'b0;
        step(); step();
        out_ready = 1'b0; in_valid = 1'b1; in_status = 8'h00;
        for (int i = 1; i <= 3; i++) begin
            in_z = 32'(i);
            step();
        end
        // z=3 still presented: only two words fit
        n_checks++;
        if (a_in_ready !== 1'b0 || a_out_z !== 32'd1 || a_out_valid !== 1'b1)
            begin n_errors++; $display("FAIL bp_full: got ready=%b z=%h, want 0 1", a_in_ready, a_out_z); end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (a_out_z !== 32'd2 || a_in_ready !== 1'b1)
            begin n_errors++; $display("FAIL bp_pop1: got z=%h ready=%b, want 2 1", a_out_z, a_in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (a_out_z !== 32'd3 || a_out_valid !== 1'b1)
            begin n_errors++; $display("FAIL bp_pop2: got z=%h v=%b, want 3 1", a_out_z, a_out_valid); end
        step();
        n_checks++;
        if (a_out_valid !== 1'b0 || a_out_z !== 32'd3)
            begin n_errors++; $display("FAIL bp_empty_hold: got v=%b z=%h, want 0 3", a_out_valid, a_out_z); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        base = 32'h3F800000 + 32'($urandom_range(0, 1000));
        out_ready = 1'b1; in_valid = 1'b1; in_status = 8'h20;
        for (int i = 0; i < 10; i++) begin
            in_z = base + 32'(i);
            step();
            n_checks++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b1 || a_out_z !== base + 32'(i))
                begin n_errors++; $display("FAIL stream_%0d: got v=%b r=%b z=%h, want 1 1 %h", i, a_out_valid, a_in_ready, a_out_z, base + 32'(i)); end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flags_clr = ($urandom_range(0, 30) == 0);
            in_z      = $urandom;
            in_status = 8'($urandom);
            step();
            n_checks++;
            if ({a_in_ready, a_out_valid} !== {mq_z.size() < 2, mq_z.size() > 0})
                begin n_errors++; $display("FAIL rand_hs_%0d: got r=%b v=%b, model size %0d", i, a_in_ready, a_out_valid, mq_z.size()); end
            n_checks++;
            if (a_out_z !== m_zc || a_out_status !== m_s || b_out_z !== m_zr)
                begin n_errors++; $display("FAIL rand_data_%0d: got z=%h st=%h raw=%h, want %h %h %h", i, a_out_z, a_out_status, b_out_z, m_zc, m_s, m_zr); end
            n_checks++;
            if (a_sticky !== m_sticky || a_res !== 16'(sat(m_res, 65535)) || a_inv !== 16'(sat(m_inv, 65535)))
                begin n_errors++; $display("FAIL rand_cnt_%0d: got sticky=%h res=%0d inv=%0d, want %h %0d %0d", i, a_sticky, a_res, a_inv, m_sticky, m_res, m_inv); end
            n_checks++;
            if (s_res !== 4'(sat(m_res, 15)) || s_inv !== 4'(sat(m_inv, 15)))
                begin n_errors++; $display("FAIL rand_sat_%0d: got res=%0d inv=%0d, want %0d %0d", i, s_res, s_inv, sat(m_res, 15), sat(m_inv, 15)); end
        end
        in_valid = 1'b0; flags_clr = 1'b0; out_ready = 1'b1;
        step(); step();
    endtask

    task automatic test_saturation();
        flags_clr = 1'b1; in_valid = 1'b0;
        step();
        flags_clr = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_status = 8'h04;
        for (int i = 0; i < 20; i++) begin
            in_z = $urandom;
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (s_inv !== 4'd15 || s_res !== 4'd15)
            begin n_errors++; $display("FAIL sat_4bit: got inv=%0d res=%0d, want 15 15", s_inv, s_res); end
        n_checks++;
        if (a_inv !== 16'd20 || a_res !== 16'd20)
            begin n_errors++; $display("FAIL sat_16bit: got inv=%0d res=%0d, want 20 20", a_inv, a_res); end
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        n_checks++;
        if (s_inv !== 4'd0 || s_res !== 4'd0 || s_sticky !== 8'h00)
            begin n_errors++; $display("FAIL sat_clear: got inv=%0d res=%0d sticky=%h, want 0 0 00", s_inv, s_res, s_sticky); end
    endtask

    task automatic test_clr_accept();
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_status = 8'h05; in_z = 32'h1;
        step();
        flags_clr = 1'b1; in_status = 8'h20; in_z = 32'h2;
        step();
        flags_clr = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (a_sticky !== 8'h20 || a_res !== 16'd1 || a_inv !== 16'd0)
            begin n_errors++; $display("FAIL clr_accept: got sticky=%h res=%0d inv=%0d, want 20 1 0", a_sticky, a_res, a_inv); end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_status = 8'h00;
        in_z = 32'hAA; step();
        in_z = 32'hBB; step();
        in_valid = 1'b0;
        n_checks++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1)
            begin n_errors++; $display("FAIL rstmid_full: got r=%b v=%b, want 0 1", a_in_ready, a_out_valid); end
        rst_n = 1'b0;
        step();
        n_checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1)
            begin n_errors++; $display("FAIL rstmid_flush: got v=%b r=%b, want 0 1", a_out_valid, a_in_ready); end
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_invalid();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_saturation();
        test_clr_accept();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
